pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Sequential next-PC and fetch front end for the MIPS single-cycle core.
- Consumes the branch decision and branch target produced by the datapath's PC+4 / branch-target stage.
- Owns the PC register, requests instructions from instruction memory over a req/ack handshake, and presents each instruction to decode with a valid/ready handshake.
- Sits between instruction memory and the decode/datapath blocks.

Parameters:
- N, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCSrc  input  1  branch taken for the issued instruction.
- Jump  input  1  jump for the issued instruction.
- PCBranch  input  N  branch target computed by the datapath.
- JumpTarget  input  26  instruction jump field, Instr[25:0].
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  N  fetch address; equals PC.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  N  fetched instruction word.
- instr_valid  output  1  Instr/PC valid to decode.
- instr_ready  input  1  decode accepts the instruction this cycle.
- Instr  output  N  registered instruction.
- PC  output  N  address of the issued instruction.

Behaviour:
- Reset is asynchronous and active-high; clock is the single clk. On reset:
  - PC=RESET_PC, Instr=0, imem_req=0, instr_valid=0, state=IDLE.
- States: IDLE, FETCH, ISSUE.
- IDLE:
  - Entered only from reset. Next edge -> FETCH.
  - imem_ack is ignored in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until ack.
  - On an edge with imem_ack=1: Instr<=imem_rdata, instr_valid<=1, state->ISSUE.
  - imem_req is 0 in ISSUE.
- ISSUE:
  - instr_valid=1; Instr and PC are held stable while instr_ready=0 (stall, unbounded).
  - On an edge with instr_ready=1, the instruction commits:
    - instr_valid<=0, state->FETCH.
    - PC<=next_pc.
- next_pc selection, priority Jump > PCSrc > sequential:
  - Jump=1: {pc4[31:28], JumpTarget, 2'b00}.
  - PCSrc=1: PCBranch.
  - Otherwise: pc4.
  - pc4 = PC+4, N bits, carry discarded. PC 32'hFFFFFFFC wraps to 32'h00000000.
- PCSrc, Jump, PCBranch and JumpTarget are sampled only on the commit edge; they are don't-care at all other times.
- imem_ack is ignored outside FETCH.
- Latency:
  - Zero-wait memory (ack in first FETCH cycle) and ready always high gives 2 cycles per instruction.
  - First instr_valid rises 2 edges after reset deassertion.
- Reset mid-operation: any outstanding request is abandoned and the FSM restarts in IDLE. A late ack arriving in IDLE has no effect.
- Jump=1 and PCSrc=1 together: Jump wins.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output port align_err (1 bit, reset 0).
  - On commit, if the selected next_pc[1:0] != 2'b00, PC loads {next_pc[N-1:2], 2'b00} and align_err is set.
  - align_err is sticky until reset.
- Not defined:
  - No align_err port; PC loads next_pc verbatim, including misaligned low bits.

Test Plan:
- Sequential fetch: reset, memory acks immediately with words 0x20080001, 0x20090002, instr_ready=1 -> imem_addr 0x0 then 0x4; Instr matches each word; instr_valid pulses every 2 cycles.
- Branch: at commit PC=0x8, PCSrc=1, PCBranch=0x40 -> next imem_addr=0x40. Jump=1 and PCSrc=1 with JumpTarget=0x000010 at PC=0x8 -> next imem_addr=0x40 (jump wins; {4'h0,26'h10,2'b00}).
- Stalls: ack delayed 3 cycles -> imem_req/imem_addr stable throughout; then instr_ready=0 for 4 cycles -> Instr/PC/instr_valid stable and no new request.
- Wrap: RESET_PC=32'hFFFFFFFC, sequential commit -> next imem_addr=32'h00000000.
- Async reset while in FETCH with ack pending -> outputs at reset values immediately, without a clock edge; late ack ignored; fetch restarts at RESET_PC.
- FETCH_ALIGN_CHECK_EN defined: PCSrc=1, PCBranch=0x42 -> imem_addr=0x40 and align_err=1, held until reset.

Source files
------------

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch front end: IDLE -> FETCH (imem req/ack) -> ISSUE (valid/ready).
// Optional FETCH_ALIGN_CHECK_EN adds a sticky align_err output and forces committed PCs word-aligned.
module pc_fetch #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc,
    input  logic         Jump,
    input  logic [N-1:0] PCBranch,
    input  logic [25:0]  JumpTarget,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [N-1:0] Instr,
    output logic [N-1:0] PC
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic         align_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [N-1:0] pc4;
    logic [N-1:0] next_pc;

    // Jump keeps the upper nibble of the sequential PC (MIPS J-type region).
    function automatic logic [N-1:0] sel_next_pc(input logic [N-1:0] seq,
                                                 input logic         jmp,
                                                 input logic         br,
                                                 input logic [N-1:0] br_tgt,
                                                 input logic [25:0]  j_tgt);
        logic [N-1:0] r;
        if (jmp)
            r = {seq[N-1:28], j_tgt, 2'b00};
        else if (br)
            r = br_tgt;
        else
            r = seq;
        return r;
    endfunction

    assign pc4     = pc_q + N'(4);
    assign next_pc = sel_next_pc(pc4, Jump, PCSrc, PCBranch, JumpTarget);

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_q, align_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        align_d = align_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                    pc_d = {next_pc[N-1:2], 2'b00};
                    if (next_pc[1:0] != 2'b00)
                        align_d = 1'b1;
`else
                    pc_d = next_pc;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            align_q <= 1'b0;
        else
            align_q <= align_d;
    end

    assign align_err = align_q;
`endif

    // Request is a pure decode of the state so it drops the instant reset is asserted.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, branch/jump priority, stalls, wrap, async reset,
// and (when FETCH_ALIGN_CHECK_EN is defined) the sticky alignment error.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic        Jump;
    logic [31:0] PCBranch;
    logic [25:0] JumpTarget;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;

    logic        req1, vld1, req2, vld2;
    logic [31:0] addr1, instr1, pc1, addr2, instr2, pc2;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        aerr1, aerr2;
`endif

    int errors = 0;
    int checks = 0;

    pc_fetch #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .Jump(Jump),
        .PCBranch(PCBranch), .JumpTarget(JumpTarget),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(vld1), .instr_ready(instr_ready), .Instr(instr1), .PC(pc1)
`ifdef FETCH_ALIGN_CHECK_EN
        , .align_err(aerr1)
`endif
    );

    pc_fetch #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .Jump(Jump),
        .PCBranch(PCBranch), .JumpTarget(JumpTarget),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(vld2), .instr_ready(instr_ready), .Instr(instr2), .PC(pc2)
`ifdef FETCH_ALIGN_CHECK_EN
        , .align_err(aerr2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        PCSrc       = 1'b0;
        Jump        = 1'b0;
        PCBranch    = 32'h0;
        JumpTarget  = 26'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b1;
        #3;
        check("rst_req",   {31'b0, req1}, 32'h0);
        check("rst_valid", {31'b0, vld1}, 32'h0);
        check("rst_instr", instr1, 32'h0);
        check("rst_pc",    pc1, 32'h0);
        check("rst_pc_wrap", pc2, 32'hFFFF_FFFC);

        // Release reset between edges; a stray ack in IDLE must not be captured.
        tick();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0001;
        tick();
        check("e1_req",   {31'b0, req1}, 32'h1);
        check("e1_addr",  addr1, 32'h0);
        check("e1_valid", {31'b0, vld1}, 32'h0);
        check("e1_addr_wrap", addr2, 32'hFFFF_FFFC);

        tick();
        check("e2_valid", {31'b0, vld1}, 32'h1);
        check("e2_instr", instr1, 32'h2008_0001);
        check("e2_req",   {31'b0, req1}, 32'h0);
        check("e2_pc",    pc1, 32'h0);
        check("e2_valid_wrap", {31'b0, vld2}, 32'h1);
        check("e2_instr_wrap", instr2, 32'h2008_0001);
        check("e2_req_wrap",   {31'b0, req2}, 32'h0);

        imem_rdata = 32'h2009_0002;
        tick();
        check("e3_addr",  addr1, 32'h4);
        check("e3_req",   {31'b0, req1}, 32'h1);
        check("e3_valid", {31'b0, vld1}, 32'h0);
        check("wrap_addr", addr2, 32'h0);
        check("wrap_pc",   pc2, 32'h0);

        tick();
        check("e4_valid", {31'b0, vld1}, 32'h1);
        check("e4_instr", instr1, 32'h2009_0002);
        check("e4_pc",    pc1, 32'h4);

        imem_rdata = 32'h1000_0004;
        tick();
        check("e5_addr", addr1, 32'h8);
        tick();
        check("e6_valid", {31'b0, vld1}, 32'h1);

        // Branch at PC=0x8.
        PCSrc    = 1'b1;
        PCBranch = 32'h40;
        tick();
        check("br_addr", addr1, 32'h40);
        check("br_req",  {31'b0, req1}, 32'h1);
        PCSrc    = 1'b0;
        tick();

        // Jump and branch together at PC=0x40: jump wins, {4'h0, 26'h20, 2'b00} = 0x80.
        Jump       = 1'b1;
        PCSrc      = 1'b1;
        PCBranch   = 32'h100;
        JumpTarget = 26'h20;
        tick();
        check("jmp_addr", addr1, 32'h80);
        Jump  = 1'b0;
        PCSrc = 1'b0;

        // Memory wait states: request and address held.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req",   {31'b0, req1}, 32'h1);
            check("wait_addr",  addr1, 32'h80);
            check("wait_valid", {31'b0, vld1}, 32'h0);
        end
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b0;
        tick();
        check("ack_instr", instr1, 32'hDEAD_BEEF);
        imem_rdata = 32'h1111_1111;

        // Decode stall: everything frozen, no new request, ack ignored.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {31'b0, vld1}, 32'h1);
            check("stall_instr", instr1, 32'hDEAD_BEEF);
            check("stall_pc",    pc1, 32'h80);
            check("stall_req",   {31'b0, req1}, 32'h0);
        end
        instr_ready = 1'b1;
        imem_ack    = 1'b0;
        tick();
        check("unstall_addr", addr1, 32'h84);
        check("unstall_req",  {31'b0, req1}, 32'h1);

        // Async reset mid-FETCH, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_req",   {31'b0, req1}, 32'h0);
        check("arst_valid", {31'b0, vld1}, 32'h0);
        check("arst_instr", instr1, 32'h0);
        check("arst_pc",    pc1, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0055;
        tick();
        reset = 1'b0;
        tick();
        check("late_ack_valid", {31'b0, vld1}, 32'h0);
        check("late_ack_instr", instr1, 32'h0);
        check("restart_addr",   addr1, 32'h0);
        check("restart_req",    {31'b0, req1}, 32'h1);
        tick();
        check("restart_instr",  instr1, 32'h0000_0055);

        // Misaligned branch target.
        PCSrc    = 1'b1;
        PCBranch = 32'h42;
        tick();
        PCSrc = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_addr",  addr1, 32'h40);
        check("mis_err",   {31'b0, aerr1}, 32'h1);
        check("mis_err_wrap", {31'b0, aerr2}, 32'h1);
`else
        check("mis_addr",  addr1, 32'h42);
`endif
        tick();
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_seq_addr", addr1, 32'h44);
        check("mis_err_sticky", {31'b0, aerr1}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mis_err_clr", {31'b0, aerr1}, 32'h0);
`else
        check("mis_seq_addr", addr1, 32'h46);
        #2;
        reset = 1'b1;
        #1;
`endif
        check("final_rst_pc", pc1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
